// File: rtl/pool_fmap_buffer.sv
// Feature-map buffer behind the 2x2 max-pool: captures 6 x FM_HEIGHT x FM_WIDTH
// in raster order, then streams it out channel-major. Optional macro FMAP_RELU_EN.
module pool_fmap_buffer #(
  parameter int FM_WIDTH  = 12,
  parameter int FM_HEIGHT = 12,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] in_ch0,
  input  logic [DATA_W-1:0] in_ch1,
  input  logic [DATA_W-1:0] in_ch2,
  input  logic [DATA_W-1:0] in_ch3,
  input  logic [DATA_W-1:0] in_ch4,
  input  logic [DATA_W-1:0] in_ch5,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [2:0]        out_ch,
  output logic              frame_done,
  output logic              overflow
);

  localparam int N  = FM_WIDTH * FM_HEIGHT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_PIX = CW'(N - 1);
  localparam logic [2:0]    LAST_CH  = 3'd5;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CW-1:0]     wr_cnt;
  logic [CW-1:0]     rd_pix;
  logic [2:0]        rd_ch;
  logic [CW-1:0]     nxt_pix;
  logic [2:0]        nxt_ch;
  logic              nxt_last;
  logic              wr_last;
  logic              hs;
  logic [DATA_W-1:0] mem [0:5][0:N-1];

  function automatic logic [DATA_W-1:0] relu_clamp(input logic [DATA_W-1:0] v);
`ifdef FMAP_RELU_EN
    relu_clamp = v[DATA_W-1] ? {DATA_W{1'b0}} : v;
`else
    relu_clamp = v;
`endif
  endfunction

  // Next-state decode and the read pointer that follows a handshake
  always_comb begin
    state_next = state;
    wr_last    = (wr_cnt == LAST_PIX);
    hs         = out_valid & out_ready;
    nxt_pix    = rd_pix + {{(CW-1){1'b0}}, 1'b1};
    nxt_ch     = rd_ch;
    if (rd_pix == LAST_PIX) begin
      nxt_pix = {CW{1'b0}};
      nxt_ch  = rd_ch + 3'd1;
    end else begin
      nxt_ch  = rd_ch;
    end
    nxt_last = (nxt_ch == LAST_CH) && (nxt_pix == LAST_PIX);
    case (state)
      FILL: begin
        if (valid_in && wr_last) begin
          state_next = DRAIN;
        end else begin
          state_next = FILL;
        end
      end
      DRAIN: begin
        if (hs && out_last) begin
          state_next = FILL;
        end else begin
          state_next = DRAIN;
        end
      end
      default: state_next = FILL;
    endcase
  end

  // Pixel storage; contents intentionally survive reset
  always_ff @(posedge clk) begin
    if (state == FILL && valid_in) begin
      mem[0][wr_cnt] <= relu_clamp(in_ch0);
      mem[1][wr_cnt] <= relu_clamp(in_ch1);
      mem[2][wr_cnt] <= relu_clamp(in_ch2);
      mem[3][wr_cnt] <= relu_clamp(in_ch3);
      mem[4][wr_cnt] <= relu_clamp(in_ch4);
      mem[5][wr_cnt] <= relu_clamp(in_ch5);
    end
  end

  // State register, counters and registered stream outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FILL;
      wr_cnt     <= {CW{1'b0}};
      rd_pix     <= {CW{1'b0}};
      rd_ch      <= 3'd0;
      out_data   <= {DATA_W{1'b0}};
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_ch     <= 3'd0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      state      <= state_next;
      frame_done <= 1'b0;
      case (state)
        FILL: begin
          if (valid_in) begin
            if (wr_last) begin
              wr_cnt    <= {CW{1'b0}};
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_data  <= mem[0][0];
              out_ch    <= 3'd0;
              out_last  <= 1'b0;
            end else begin
              wr_cnt <= wr_cnt + {{(CW-1){1'b0}}, 1'b1};
            end
          end
        end
        DRAIN: begin
          // Pixels arriving while draining are lost; flag it until reset
          if (valid_in) begin
            overflow <= 1'b1;
          end
          if (hs) begin
            if (out_last) begin
              out_valid  <= 1'b0;
              out_last   <= 1'b0;
              rd_pix     <= {CW{1'b0}};
              rd_ch      <= 3'd0;
              in_ready   <= 1'b1;
              frame_done <= 1'b1;
            end else begin
              rd_pix   <= nxt_pix;
              rd_ch    <= nxt_ch;
              out_data <= mem[nxt_ch][nxt_pix];
              out_ch   <= nxt_ch;
              out_last <= nxt_last;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_fmap_buffer.sv
// Scoreboard bench for pool_fmap_buffer: expected stream queued at fill time,
// popped on each output handshake.
module tb_pool_fmap_buffer;

  localparam int N = 144;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] in_ch [6];
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [2:0]  out_ch;
  logic        frame_done;
  logic        overflow;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  ch;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pool_fmap_buffer #(.FM_WIDTH(12), .FM_HEIGHT(12), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in),
    .in_ch0(in_ch[0]), .in_ch1(in_ch[1]), .in_ch2(in_ch[2]),
    .in_ch3(in_ch[3]), .in_ch4(in_ch[4]), .in_ch5(in_ch[5]),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .out_ch(out_ch),
    .frame_done(frame_done), .overflow(overflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic fill_frame(input bit gaps, input bit neg0);
    exp_t e;
    for (int p = 0; p < N; p++) begin
      @(negedge clk);
      if (p == 0) begin
        check_eq("fill_in_ready", in_ready, 32'd1);
        check_eq("fill_frame_done_low", frame_done, 32'd0);
      end
      if (gaps) begin
        while ($urandom_range(3) == 0) begin
          valid_in = 1'b0;
          @(negedge clk);
        end
      end
      valid_in = 1'b1;
      for (int k = 0; k < 6; k++) in_ch[k] = 32'(k * 1000 + p);
      if (neg0 && p == 0) in_ch[0] = 32'hFFFF_FFFB;
    end
    @(negedge clk);
    valid_in = 1'b0;
    for (int k = 0; k < 6; k++) begin
      for (int p = 0; p < N; p++) begin
        e.data = 32'(k * 1000 + p);
        if (neg0 && k == 0 && p == 0) begin
`ifdef FMAP_RELU_EN
          e.data = 32'd0;
`else
          e.data = 32'hFFFF_FFFB;
`endif
        end
        e.ch   = 3'(k);
        e.last = (k == 5) && (p == N - 1);
        sb.push_back(e);
      end
    end
  endtask

  task automatic drain(input int max_el, input bit rnd, input bit inject);
    int got = 0;
    int cyc = 0;
    while (got < max_el && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      out_ready = rnd ? 1'($urandom_range(1)) : 1'b1;
      valid_in  = inject && ($urandom_range(4) == 0);
      check_eq("out_valid", out_valid, 32'd1);
      if (sb.size() > 0) begin
        check_eq("out_data", out_data, sb[0].data);
        check_eq("out_ch", out_ch, 32'(sb[0].ch));
        check_eq("out_last", out_last, 32'(sb[0].last));
        if (out_ready && out_valid) begin
          void'(sb.pop_front());
          got++;
        end
      end
    end
    if (got < max_el) check_eq("drain_timeout", got, max_el);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    valid_in  = 1'b0;
  endtask

  task automatic post_frame(input logic ovf);
    @(negedge clk);
    check_eq("frame_done", frame_done, 32'd1);
    check_eq("post_out_valid", out_valid, 32'd0);
    check_eq("post_in_ready", in_ready, 32'd1);
    check_eq("overflow", overflow, 32'(ovf));
    check_eq("sb_drained", sb.size(), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    valid_in  = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) in_ch[k] = 32'd0;
    #12;
    check_eq("rst_out_valid", out_valid, 32'd0);
    check_eq("rst_in_ready", in_ready, 32'd1);
    check_eq("rst_out_data", out_data, 32'd0);
    check_eq("rst_out_last", out_last, 32'd0);
    check_eq("rst_overflow", overflow, 32'd0);
    check_eq("rst_frame_done", frame_done, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // full-throughput frame
    fill_frame(1'b0, 1'b0);
    drain(864, 1'b0, 1'b0);
    post_frame(1'b0);

    // random stalls, gapped fill
    fill_frame(1'b1, 1'b0);
    drain(864, 1'b1, 1'b0);
    post_frame(1'b0);

    // pixels injected during drain
    fill_frame(1'b0, 1'b0);
    drain(864, 1'b1, 1'b1);
    post_frame(1'b1);

    // next frame after overflow starts at pixel 0
    fill_frame(1'b1, 1'b0);
    drain(864, 1'b0, 1'b0);
    post_frame(1'b1);

    // reset mid-drain
    fill_frame(1'b0, 1'b0);
    drain(300, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midrst_out_valid", out_valid, 32'd0);
    check_eq("midrst_in_ready", in_ready, 32'd1);
    check_eq("midrst_overflow", overflow, 32'd0);
    check_eq("midrst_out_last", out_last, 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    fill_frame(1'b0, 1'b0);
    drain(864, 1'b0, 1'b0);
    post_frame(1'b0);

    // negative value at ch0 pixel 0
    fill_frame(1'b0, 1'b1);
    drain(864, 1'b1, 1'b0);
    post_frame(1'b0);

    // back-to-back frames, fill starts right after frame_done
    fill_frame(1'b0, 1'b0);
    drain(864, 1'b0, 1'b0);
    post_frame(1'b0);
    fill_frame(1'b0, 1'b0);
    drain(864, 1'b1, 1'b0);
    post_frame(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
